colour_selector: RTL

COLOUR_SELECTOR -- requirements
Module: colour_selector

---
 rtl/colour_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/colour_selector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/colour_pkg.sv
// Shared palette, index width and selector state encoding for the colour path
// and any render stage that needs to interpret color_idx.
package colour_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [15:0]      rgb565_t;

  localparam rgb565_t C_RED   = 16'hF800;
  localparam rgb565_t C_GREEN = 16'h07E0;
  localparam rgb565_t C_BLUE  = 16'h001F;
  localparam rgb565_t C_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } sel_state_e;

  function automatic rgb565_t palette(input idx_t i_idx);
    rgb565_t w_col;
    case (i_idx)
      2'd0:    w_col = C_RED;
      2'd1:    w_col = C_GREEN;
      2'd2:    w_col = C_BLUE;
      default: w_col = C_WHITE;
    endcase
    return w_col;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a level debouncer; emits the debounced
// level plus single-cycle pulses registered in the same edge the level flips.
module btn_debounce
  import colour_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5_000_000
) (
  input  logic i_clk25,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync != r_db) begin
        // Flip on the cycle the count would reach DEBOUNCE_CYCLES.
        if (r_cnt == CNT_LAST) begin
          r_db   <= ~r_db;
          r_cnt  <= '0;
          r_rise <= ~r_db;
          r_fall <= r_db;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/colour_selector.sv
// Push-button colour selector: debounced press advances the palette index,
// holding the button auto-repeats after a hold delay.
//   state     | meaning
//   ST_IDLE   | button released, waiting for a debounced press
//   ST_HELD   | pressed, timing the hold delay before auto-repeat
//   ST_REPEAT | still held, advancing every repeat period
module colour_selector
  import colour_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             enable,
  output logic [15:0]      color_out,
  output logic [IDX_W-1:0] color_idx,
  output logic             changed
);

  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

  logic w_db;
  logic w_rise;
  logic w_fall;
  logic w_release;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk25 (clk25),
    .i_rst_n (rst_n),
    .i_btn   (btn),
    .o_db    (w_db),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_release = w_fall | ~w_db;

  sel_state_e       r_state;
  sel_state_e       w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             w_step;
  logic             w_adv;
  idx_t             r_idx;
  idx_t             w_idx_nxt;
  rgb565_t          r_color;
  logic             r_changed;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_HELD;
          w_step      = 1'b1;
        end
      end
      ST_HELD: begin
        // Release wins over a simultaneous timer expiry.
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == HOLD_LAST) begin
          w_state_nxt = ST_REPEAT;
          w_tmr_nxt   = '0;
          w_step      = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == REPEAT_LAST) begin
          w_tmr_nxt = '0;
          w_step    = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  assign w_adv     = w_step & enable;
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_idx     <= '0;
      r_color   <= C_RED;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_changed <= w_adv;
      if (w_adv) begin
        r_idx   <= w_idx_nxt;
        r_color <= palette(w_idx_nxt);
      end
    end
  end

  assign color_out = r_color;
  assign color_idx = r_idx;
  assign changed   = r_changed;

endmodule
